// File: rtl/kmac_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kmac_pkg : KMAC command encodings and sparse scheduler state encoding (rev 1.0)
// ----------------------------------------------------------------------------
package kmac_pkg;

  localparam int CmdWidth = 4;

  typedef enum logic [CmdWidth-1:0] {
    CmdNone      = 4'b0000,
    CmdStart     = 4'b1101,
    CmdProcess   = 4'b1010,
    CmdManualRun = 4'b0110,
    CmdDone      = 4'b1011
  } kmac_cmd_e;

  localparam int SchedStWidth = 7;

  // Nonzero codewords of a [7,4] Hamming code: pairwise distance >= 3, all-zero is illegal.
  typedef enum logic [SchedStWidth-1:0] {
    StIdle      = 7'b0001111,
    StAppStart  = 7'b0010011,
    StAppFeed   = 7'b0011100,
    StAppWait   = 7'b0100101,
    StAppDigest = 7'b0101010,
    StSwOwn     = 7'b0110110,
    StTerminal  = 7'b0111001
  } sched_st_e;

  localparam logic [15:0] TimeoutCyclesDefault = 16'd4096;

endpackage
`default_nettype wire

// File: rtl/kmac_rr_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kmac_rr_arb : round-robin one-hot arbiter, pointer advances past each grant (rev 1.0)
// ----------------------------------------------------------------------------
module kmac_rr_arb #(
  parameter int NumReq = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              take_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              valid_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int SumW = PtrW + 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NumReq - 1);

  logic [PtrW-1:0] ptr_q, ptr_d, sel;
  logic [SumW-1:0] sum;
  logic            found;

  assign valid_o = |req_i;

  // Scan requesters starting at the pointer, wrapping modulo NumReq.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    sel   = '0;
    for (int i = 0; i < NumReq; i++) begin
      sum = {1'b0, ptr_q} + SumW'(i);
      if (sum >= SumW'(NumReq)) begin
        sum = sum - SumW'(NumReq);
      end
      sel = sum[PtrW-1:0];
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        ptr_d      = (sel == LastIdx) ? '0 : sel + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (take_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prim_sparse_fsm_flop.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prim_sparse_fsm_flop : state register for sparse-encoded FSMs (rev 1.0)
// ----------------------------------------------------------------------------
module prim_sparse_fsm_flop #(
  parameter int                Width      = 7,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ResetValue;
    end else begin
      state_q <= state_i;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/kmac_cmd_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kmac_cmd_sched : KMAC command-stream owner, app/SW arbitration and sequencing (rev 1.0)
// ----------------------------------------------------------------------------
module kmac_cmd_sched
  import kmac_pkg::*;
#(
  parameter int                   NumApp        = 3,
  parameter int                   TimeoutW      = 16,
  parameter logic [TimeoutW-1:0]  TimeoutCycles = TimeoutW'(TimeoutCyclesDefault)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumApp-1:0] app_req_i,
  input  logic [NumApp-1:0] app_last_i,
  input  logic [NumApp-1:0] app_ack_i,
  output logic [NumApp-1:0] app_gnt_o,
  output logic [NumApp-1:0] app_done_o,
  input  kmac_cmd_e         sw_cmd_i,
  output logic              sw_owner_o,
  output kmac_cmd_e         cmd_o,
  input  logic              absorbed_i,
  output logic              err_timeout_o,
  output logic              sparse_fsm_error_o
);

  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutCycles - TimeoutW'(1);

  sched_st_e               state_q, state_d;
  logic [SchedStWidth-1:0] state_raw;
  kmac_cmd_e               cmd_q, cmd_d;
  logic [NumApp-1:0]       gnt_q, gnt_d, done_q, done_d, arb_gnt;
  logic                    sw_owner_q, sw_owner_d, err_q, err_d, fsm_err;
  logic                    arb_take, arb_valid;
  logic [TimeoutW-1:0]     cnt_q, cnt_d;
  logic                    owner_req, owner_last, owner_ack;

  // Masking with the grant makes non-owner inputs invisible.
  assign owner_req  = |(app_req_i  & gnt_q);
  assign owner_last = |(app_last_i & gnt_q);
  assign owner_ack  = |(app_ack_i  & gnt_q);
  assign arb_take   = (state_q == StIdle) && arb_valid;

  kmac_rr_arb #(
    .NumReq (NumApp)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (app_req_i),
    .take_i  (arb_take),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  prim_sparse_fsm_flop #(
    .Width      (SchedStWidth),
    .ResetValue (StIdle)
  ) u_state_regs (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .state_i (state_d),
    .state_o (state_raw)
  );

  assign state_q = sched_st_e'(state_raw);

  always_comb begin
    state_d    = state_q;
    cmd_d      = CmdNone;
    gnt_d      = gnt_q;
    done_d     = '0;
    sw_owner_d = sw_owner_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    fsm_err    = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          state_d = StAppStart;
        end else if (sw_cmd_i == CmdStart) begin
          sw_owner_d = 1'b1;
          cmd_d      = CmdStart;
          state_d    = StSwOwn;
        end
      end
      // Start is always issued; an early request drop is caught in StAppFeed.
      StAppStart: begin
        cmd_d   = CmdStart;
        state_d = StAppFeed;
      end
      StAppFeed: begin
        if (!owner_req) begin
          cmd_d   = CmdDone;
          gnt_d   = '0;
          state_d = StIdle;
        end else if (owner_last) begin
          cmd_d   = CmdProcess;
          cnt_d   = '0;
          state_d = StAppWait;
        end
      end
      StAppWait: begin
        cnt_d = cnt_q + TimeoutW'(1);
        if (absorbed_i) begin
          done_d  = gnt_q;
          state_d = StAppDigest;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          cmd_d   = CmdDone;
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      StAppDigest: begin
        if (!owner_req || owner_ack) begin
          cmd_d   = CmdDone;
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      StSwOwn: begin
        cmd_d = sw_cmd_i;
        if (sw_cmd_i == CmdDone) begin
          sw_owner_d = 1'b0;
          state_d    = StIdle;
        end
      end
      StTerminal: begin
        gnt_d      = '0;
        sw_owner_d = 1'b0;
        fsm_err    = 1'b1;
      end
      default: begin
        state_d    = StTerminal;
        gnt_d      = '0;
        sw_owner_d = 1'b0;
        fsm_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_q      <= CmdNone;
      gnt_q      <= '0;
      done_q     <= '0;
      sw_owner_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      cmd_q      <= cmd_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      sw_owner_q <= sw_owner_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cmd_o              = cmd_q;
  assign app_gnt_o          = gnt_q;
  assign app_done_o         = done_q;
  assign sw_owner_o         = sw_owner_q;
  assign err_timeout_o      = err_q;
  assign sparse_fsm_error_o = fsm_err;

endmodule
`default_nettype wire

// File: doc/kmac_cmd_sched.md
Name: kmac_cmd_sched

Overview:
- Owns the single KMAC command stream (`kmac_cmd_e`) that drives the command-sequence checker and SHA3 core.
- Arbitrates ownership of one complete hash operation (Start..Done) between NumApp hardware application requesters and the SW register interface.
- Generates the Start/Process/Done command sequence on behalf of application requesters.
- Sits between the app interfaces / CSR command register and the error-check/core command input.

Parameters:
- NumApp, 3: number of hardware application requesters.
- TimeoutW, 16: width of the absorb-wait timeout counter.
- TimeoutCycles, 16'd4096: cycles allowed in WaitAbsorb before a timeout is flagged. Must satisfy 0 < TimeoutCycles < 2**TimeoutW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- app_req_i  in  NumApp  requester wants a hash operation; held high until app_done_o.
- app_last_i  in  NumApp  owner's final message beat accepted this cycle.
- app_ack_i  in  NumApp  owner consumed digest.
- app_gnt_o  out  NumApp  one-hot ownership; held for the whole operation.
- app_done_o  out  NumApp  one-cycle pulse when the digest is available to the owner.
- sw_cmd_i  in  kmac_pkg::CmdWidth  SW command from CSR.
- sw_owner_o  out  1  SW currently owns the engine.
- cmd_o  out  kmac_pkg::CmdWidth  command to downstream; registered.
- absorbed_i  in  1  SHA3 absorb complete pulse.
- err_timeout_o  out  1  one-cycle pulse on absorb timeout.
- sparse_fsm_error_o  out  1  illegal state encoding; combinational.

Behaviour:
- Reset values: cmd_o=CmdNone, app_gnt_o=0, app_done_o=0, sw_owner_o=0, err_timeout_o=0, state=StIdle, rr pointer=0, counter=0.
- State register is sparse-encoded, minimum Hamming distance 3, and instantiated through prim_sparse_fsm_flop.
- States: StIdle, StAppStart, StAppFeed, StAppWait, StAppDigest, StSwOwn, StTerminal.
- StIdle:
  - If any app_req_i is high, grant round-robin starting from the rr pointer and go to StAppStart.
  - rr pointer becomes granted index + 1, wrapping from NumApp-1 to 0.
  - Otherwise, if sw_cmd_i==CmdStart, set sw_owner_o, pass CmdStart, and go to StSwOwn.
  - If an app request and SW CmdStart arrive in the same cycle, the app wins and the SW Start is dropped (cmd_o stays CmdNone).
- StAppStart: cmd_o=CmdStart for exactly one cycle, then StAppFeed.
- StAppFeed: on app_last_i[owner], cmd_o=CmdProcess next cycle, clear the counter, go to StAppWait.
- StAppWait:
  - Counter increments each cycle.
  - On absorbed_i, go to StAppDigest and pulse app_done_o[owner] on the next cycle.
  - If the counter reaches TimeoutCycles before absorbed_i:
    - pulse err_timeout_o;
    - cmd_o=CmdDone for one cycle;
    - drop the grant;
    - go to StIdle.
  - absorbed_i in the same cycle as the counter reaching TimeoutCycles counts as success.
- StAppDigest: on app_ack_i[owner], cmd_o=CmdDone for one cycle, drop the grant, go to StIdle.
- App ownership loss:
  - If app_req_i[owner] drops in StAppStart, StAppFeed or StAppDigest, abort: cmd_o=CmdDone, go to StIdle.
  - In StAppStart the abort takes effect after the Start cycle.
- StSwOwn:
  - cmd_o <= sw_cmd_i each cycle.
  - On sw_cmd_i==CmdDone, clear sw_owner_o after that cycle and go to StIdle.
  - App requests wait; SW is never pre-empted.
- Command output rules:
  - All commands not listed above are CmdNone.
  - cmd_o is registered, so latency from decision to cmd_o is 1 cycle.
  - The sequence emitted for an app always satisfies Idle→Start→Process→Done ordering.
- Grant and inputs:
  - At most one app_gnt_o bit is high; it is never high together with sw_owner_o.
  - Inputs from non-owners are ignored.
- StTerminal:
  - Any illegal encoding drives sparse_fsm_error_o=1 and enters StTerminal.
  - StTerminal is absorbing until reset, with all grants 0 and cmd_o=CmdNone.
- Reset mid-operation: returns to reset values next edge; no CmdDone is emitted.

Decomposition:
- kmac_pkg additions:
  - sched_st_e sparse encoding, width 7;
  - TimeoutCycles default constant;
  - the existing kmac_cmd_e and CmdWidth reuse.
- Sub-module: kmac_rr_arb (round-robin one-hot arbiter with pointer update on grant).
- The FSM, counter and cmd_o register stay in the top module.

Test Plan:
- App0 single operation:
  - Stimulus: req0=1; app_last_i[0] at cycle 10; absorbed_i at 20; app_ack_i[0] at 25.
  - Expected cmd_o: Start, Process, Done, each exactly one cycle.
  - Expected app_done_o[0]: one pulse, 1 cycle after absorbed_i.
- Round-robin:
  - Stimulus: req0, req1 and req2 held high continuously.
  - Expected grant order: 0, 1, 2, 0, with the pointer wrapping correctly.
- Collision and no pre-emption:
  - App1 request and sw_cmd_i=CmdStart in the same Idle cycle: grant app1, no SW Start on cmd_o, sw_owner_o=0.
  - Later SW Start while app owns: dropped.
  - SW owning then app request: app waits until SW CmdDone.
- Timeout:
  - Stimulus: TimeoutCycles=8, no absorbed_i.
  - Expected: err_timeout_o pulses after 8 wait cycles; CmdDone; grant cleared; state StIdle.
  - absorbed_i at cycle 8 exactly: no timeout.
- Abort and reset:
  - req0 drops in StAppFeed: CmdDone, grant cleared.
  - rst_i in StAppWait: all outputs at reset values next cycle; no CmdDone.
- Fault injection:
  - Force the state register to 7'h00: sparse_fsm_error_o=1, grants 0, cmd_o=CmdNone, stays until rst_i.
